conv_maxpool2x2: RTL and testbench

//  Downstream stage of the conv kernel: consumes the quantized activation stream (acc_o/vld_o)
//  in raster order, one pixel per valid, for one output channel.

---
 rtl/conv_maxpool2x2_pkg.sv | 17 +
 rtl/conv_maxpool2x2_pool_line_buf.sv | 33 +++
 rtl/conv_maxpool2x2.sv | 169 ++++++++++++++++
 tb/tb_conv_maxpool2x2.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_maxpool2x2_pkg.sv
// Shared definitions for the conv accelerator pooling stage.
//   DEF_ACT_BITS : activation width (unsigned, post-ReLU)
//   DEF_MAX_W    : maximum frame width in pixels (even)
//   DEF_DIM_BITS : width of the frame geometry ports
//   pool_state_t : control FSM encoding
package conv_maxpool2x2_pkg;

    localparam int DEF_ACT_BITS = 8;
    localparam int DEF_MAX_W    = 256;
    localparam int DEF_DIM_BITS = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pool_state_t;

endpackage

// File: rtl/conv_maxpool2x2_pool_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the even row
// until the matching odd row arrives. No reset: contents are always written
// before they are read within a frame.
//   clk   : clock
//   we    : write enable
//   waddr : write index (pixel column >> 1)
//   wdata : horizontal max to store
//   raddr : read index (pixel column >> 1)
//   rdata : combinational read data
module pool_line_buf #(
    parameter int DEPTH     = 128,
    parameter int ACT_BITS  = 8,
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [ACT_BITS-1:0]  wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [ACT_BITS-1:0]  rdata
);

    logic [ACT_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 max-pool (or bypass) on a raster-order activation stream.
//   clk, rstn   : clock, asynchronous active-low reset
//   start       : latch is_pool/width/height, clear counters, (re)enter RUN
//   is_pool     : 1 = max-pool, 0 = bypass
//   width       : frame width 1..MAX_W
//   height      : frame height >= 1
//   vld_i, din  : input pixel stream, one pixel per valid
//   dout, vld_o : output pixel stream, latency 1
//   frame_done  : pulse with the frame's final output cycle
//   err_overrun : sticky, pixel seen while idle; cleared by start
module conv_maxpool2x2
    import conv_maxpool2x2_pkg::*;
#(
    parameter int ACT_BITS = DEF_ACT_BITS,
    parameter int MAX_W    = DEF_MAX_W,
    parameter int DIM_BITS = DEF_DIM_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                is_pool,
    input  logic [DIM_BITS-1:0] width,
    input  logic [DIM_BITS-1:0] height,
    input  logic                vld_i,
    input  logic [ACT_BITS-1:0] din,
    output logic [ACT_BITS-1:0] dout,
    output logic                vld_o,
    output logic                frame_done,
    output logic                err_overrun
);

    localparam int ADDR_BITS = $clog2(MAX_W / 2);

    function automatic logic [ACT_BITS-1:0] umax(input logic [ACT_BITS-1:0] a,
                                                 input logic [ACT_BITS-1:0] b);
        return (a > b) ? a : b;
    endfunction

    pool_state_t state_q, state_d;

    logic                 pool_lat;
    logic [DIM_BITS-1:0]  w_lat, h_lat, col, row;
    logic                 accept, col_last, row_last, frame_last;
    logic [ACT_BITS-1:0]  hmax_p0, pm, lb_rd, pool_max;
    logic                 lb_we;
    logic [ADDR_BITS-1:0] lb_addr;
    logic                 out_en;

    logic [ACT_BITS-1:0]  dout_p1;
    logic                 vld_p1, done_p1, err_q;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start always (re)enters RUN, aborting any frame in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (accept && frame_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: a pixel coinciding with start is dropped
    always_comb begin
        accept = 1'b0;
        if (state_q == ST_RUN && vld_i && !start) begin
            accept = 1'b1;
        end
    end

    assign col_last   = (col == w_lat - DIM_BITS'(1));
    assign row_last   = (row == h_lat - DIM_BITS'(1));
    assign frame_last = col_last && row_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pool_lat <= 1'b0;
            w_lat    <= '0;
            h_lat    <= '0;
            col      <= '0;
            row      <= '0;
        end else if (start) begin
            pool_lat <= is_pool;
            w_lat    <= width;
            h_lat    <= height;
            col      <= '0;
            row      <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row + DIM_BITS'(1);
            end else begin
                col <= col + DIM_BITS'(1);
            end
        end
    end

    // Stage p0: horizontal max register captures the even-column pixel
    always_ff @(posedge clk) begin
        if (accept && !col[0]) begin
            hmax_p0 <= din;
        end
    end

    assign pm      = umax(hmax_p0, din);
    assign lb_addr = col[ADDR_BITS:1];
    // Only even rows write and only odd rows read, so a same-index
    // read/write collision cannot happen.
    assign lb_we   = accept && pool_lat && !row[0] && col[0];

    pool_line_buf #(
        .DEPTH    (MAX_W / 2),
        .ACT_BITS (ACT_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_line_buf (
        .clk  (clk),
        .we   (lb_we),
        .waddr(lb_addr),
        .wdata(pm),
        .raddr(lb_addr),
        .rdata(lb_rd)
    );

    assign pool_max = umax(pm, lb_rd);
    // Odd W leaves the last column unpaired and odd H leaves the last row
    // unpaired; neither ever reaches an odd/odd position, so no output.
    assign out_en   = accept && (!pool_lat || (row[0] && col[0]));

    // Stage p1: output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_p1  <= out_en;
            done_p1 <= accept && frame_last;
            if (out_en) begin
                dout_p1 <= pool_lat ? pool_max : din;
            end
            if (start) begin
                err_q <= 1'b0;
            end else if (state_q == ST_IDLE && vld_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign dout        = dout_p1;
    assign vld_o       = vld_p1;
    assign frame_done  = done_p1;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
module tb_conv_maxpool2x2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       is_pool = 1'b0;
    logic [8:0] width = 9'd1;
    logic [8:0] height = 9'd1;
    logic       vld_i = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       vld_o;
    logic       frame_done;
    logic       err_overrun;

    int checks = 0;
    int failures = 0;

    conv_maxpool2x2 dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .is_pool    (is_pool),
        .width      (width),
        .height     (height),
        .vld_i      (vld_i),
        .din        (din),
        .dout       (dout),
        .vld_o      (vld_o),
        .frame_done (frame_done),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic pool, input int w, input int h);
        start   = 1'b1;
        is_pool = pool;
        width   = 9'(w);
        height  = 9'(h);
        cyc();
        start   = 1'b0;
    endtask

    task automatic pix(input logic [7:0] d);
        vld_i = 1'b1;
        din   = d;
        cyc();
    endtask

    // Pixel pattern for the full-width frame: 255 at the line end, small values elsewhere
    function automatic logic [7:0] px5(input int r, input int c);
        if (c == 255) return 8'd255;
        return 8'((c ^ (r * 3)) & 127);
    endfunction

    function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    initial begin
        logic [7:0] t3_din [15];
        logic [7:0] t6_din [4];
        logic [7:0] exp_d;
        int nout;

        t3_din = '{8'd12, 8'd200, 8'd7, 8'd99, 8'd250,
                   8'd45, 8'd3, 8'd180, 8'd181, 8'd255,
                   8'd90, 8'd91, 8'd92, 8'd93, 8'd94};
        t6_din = '{8'd9, 8'd3, 8'd4, 8'd8};

        // ---- 1: reset ----
        #3;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_vld", 32'(vld_o), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(err_overrun), 0);
        cyc();
        rstn = 1'b1;
        cyc();

        do_start(1'b0, 3, 2);
        pix(8'h5A);
        vld_i = 1'b0;
        chk("mid_pre_dout", 32'(dout), 32'h5A);
        chk("mid_pre_vld", 32'(vld_o), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(dout), 0);
        chk("mid_rst_vld", 32'(vld_o), 0);
        chk("mid_rst_done", 32'(frame_done), 0);
        cyc();
        rstn = 1'b1;
        cyc();

        pix(8'd3);
        vld_i = 1'b0;
        chk("idle_err", 32'(err_overrun), 1);
        chk("idle_vld", 32'(vld_o), 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_err_clr", 32'(err_overrun), 0);
        cyc();
        rstn = 1'b1;
        cyc();

        // ---- 2: pool W=4 H=2, din 0..7 ----
        do_start(1'b1, 4, 2);
        for (int i = 0; i < 8; i++) begin
            pix(8'(i));
            chk($sformatf("t2_vld_%0d", i), 32'(vld_o), 32'((i == 5) || (i == 7)));
            chk($sformatf("t2_done_%0d", i), 32'(frame_done), 32'(i == 7));
            if (i == 5) chk("t2_dout_a", 32'(dout), 5);
            if (i == 7) chk("t2_dout_b", 32'(dout), 7);
        end
        vld_i = 1'b0;
        cyc();
        chk("t2_vld_after", 32'(vld_o), 0);
        chk("t2_done_after", 32'(frame_done), 0);

        // ---- 3: pool W=5 H=3, unpaired column 4 and row 2 ----
        do_start(1'b1, 5, 3);
        chk("t3_err_clear", 32'(err_overrun), 0);
        for (int i = 0; i < 15; i++) begin
            pix(t3_din[i]);
            chk($sformatf("t3_vld_%0d", i), 32'(vld_o), 32'((i == 6) || (i == 8)));
            chk($sformatf("t3_done_%0d", i), 32'(frame_done), 32'(i == 14));
            if (i == 6) chk("t3_dout_a", 32'(dout), 200);
            if (i == 8) chk("t3_dout_b", 32'(dout), 181);
        end
        vld_i = 1'b0;
        cyc();

        // ---- 4: bypass W=3 H=2, din 10..15 ----
        do_start(1'b0, 3, 2);
        for (int i = 0; i < 6; i++) begin
            pix(8'(10 + i));
            chk($sformatf("t4_vld_%0d", i), 32'(vld_o), 1);
            chk($sformatf("t4_dout_%0d", i), 32'(dout), 32'(10 + i));
            chk($sformatf("t4_done_%0d", i), 32'(frame_done), 32'(i == 5));
        end
        vld_i = 1'b0;
        cyc();
        chk("t4_vld_after", 32'(vld_o), 0);

        // ---- 5: pool W=256 H=4, back-to-back, 255 at line end ----
        do_start(1'b1, 256, 4);
        nout = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 256; c++) begin
                pix(px5(r, c));
                if (vld_o === 1'b1) nout++;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_d = max4(px5(r - 1, c - 1), px5(r - 1, c), px5(r, c - 1), px5(r, c));
                    chk($sformatf("t5_vld_r%0d_c%0d", r, c), 32'(vld_o), 1);
                    chk($sformatf("t5_dout_r%0d_c%0d", r, c), 32'(dout), 32'(exp_d));
                end else begin
                    chk($sformatf("t5_vld_r%0d_c%0d", r, c), 32'(vld_o), 0);
                end
            end
        end
        chk("t5_done", 32'(frame_done), 1);
        chk("t5_last_dout", 32'(dout), 255);
        vld_i = 1'b0;
        chk("t5_nout", 32'(nout), 256);
        // Frame finished: block is idle again, so a stray pixel flags overrun
        pix(8'd1);
        vld_i = 1'b0;
        chk("t5_idle_err", 32'(err_overrun), 1);

        // ---- 6: abort mid row 1, then W=2 H=2 frame ----
        do_start(1'b1, 4, 2);
        for (int i = 0; i < 5; i++) begin
            pix(8'(100 + i));
            chk($sformatf("t6_abort_vld_%0d", i), 32'(vld_o), 0);
        end
        // start with a simultaneous pixel: start wins, pixel dropped
        start   = 1'b1;
        is_pool = 1'b1;
        width   = 9'd2;
        height  = 9'd2;
        vld_i   = 1'b1;
        din     = 8'd250;
        cyc();
        start = 1'b0;
        chk("t6_restart_vld", 32'(vld_o), 0);
        chk("t6_restart_err", 32'(err_overrun), 0);
        for (int i = 0; i < 4; i++) begin
            pix(t6_din[i]);
            chk($sformatf("t6_vld_%0d", i), 32'(vld_o), 32'(i == 3));
            chk($sformatf("t6_done_%0d", i), 32'(frame_done), 32'(i == 3));
            if (i == 3) chk("t6_dout", 32'(dout), 9);
        end
        vld_i = 1'b0;
        cyc();
        chk("t6_vld_after", 32'(vld_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
